// File: rtl/pipelined_control_unit_if.sv
// Fetch/hazard-side inputs and decode/execute control outputs of the control unit.
// CU_PERF_COUNTERS_EN adds the instr_count / bubble_count performance outputs.
interface pipelined_control_unit_if #(
    parameter int OP_W  = 4,
    parameter int ALU_W = 4
);
    logic             instr_valid;
    logic [OP_W-1:0]  operation;
    logic             imm;
    logic             stall;
    logic             flush;
    logic             resume;
    logic             fetch_en;
    logic             ex_valid;
    logic             regWrite;
    logic             memWrite;
    logic             jump;
    logic             branch;
    logic             aluSrc;
    logic             a1Source;
    logic             mxSource;
    logic [1:0]       resultSrc;
    logic [ALU_W-1:0] aluControl;
    logic             stop;
    logic             halted;
    logic             readDataVGA;
`ifdef CU_PERF_COUNTERS_EN
    logic [31:0]      instr_count;
    logic [31:0]      bubble_count;
`endif

    modport master (
        output instr_valid, operation, imm, stall, flush, resume,
        input  fetch_en, ex_valid, regWrite, memWrite, jump, branch, aluSrc,
        input  a1Source, mxSource, resultSrc, aluControl, stop, halted, readDataVGA
`ifdef CU_PERF_COUNTERS_EN
        , input instr_count, bubble_count
`endif
    );

    modport slave (
        input  instr_valid, operation, imm, stall, flush, resume,
        output fetch_en, ex_valid, regWrite, memWrite, jump, branch, aluSrc,
        output a1Source, mxSource, resultSrc, aluControl, stop, halted, readDataVGA
`ifdef CU_PERF_COUNTERS_EN
        , output instr_count, bubble_count
`endif
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// Decodes opcode+imm into a registered decode/execute control word, with END/drain/halt FSM (perf counters: CU_PERF_COUNTERS_EN).
// Latency: one edge from operation/instr_valid to the ex_* outputs; stop/halted are registered.
// Backpressure: stall holds the word, flush loads a bubble; fetch_en drops while stalled or not running.
module pipelined_control_unit #(
    parameter int OP_W         = 4,
    parameter int ALU_W        = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input logic                   clk,
    input logic                   rst_n,
    pipelined_control_unit_if.slave cu
);
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    typedef struct packed {
        logic             exValid;
        logic             regWrite;
        logic             memWrite;
        logic             jump;
        logic             branch;
        logic             aluSrc;
        logic             a1Source;
        logic             mxSource;
        logic [1:0]       resultSrc;
        logic [ALU_W-1:0] aluControl;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    logic [1:0]  state, nextState;
    logic [3:0]  drainCnt, nextCnt;
    ctrl_t       exReg, decoded;
    logic        stopReg, haltedReg, vgaReg;
    logic [31:0] opVal;
    logic        isEnd, running, loadWord, acceptEnd, runBubble;

    assign opVal = 32'(cu.operation);
    assign isEnd = (opVal >= 32'd13);

    always_comb begin
        decoded            = BUBBLE;
        decoded.exValid    = 1'b1;
        decoded.aluControl = (opVal <= 32'd11) ? ALU_W'(cu.operation) : '0;
        case (opVal)
            32'd0, 32'd1, 32'd2, 32'd3, 32'd4: decoded.regWrite = 1'b1;
            32'd5: begin
                decoded.aluSrc   = cu.imm;
                decoded.a1Source = 1'b1;
            end
            32'd6: begin
                decoded.regWrite = 1'b1;
                decoded.aluSrc   = cu.imm;
                decoded.a1Source = 1'b1;
                decoded.mxSource = cu.imm;
            end
            32'd7: begin
                decoded.regWrite  = 1'b1;
                decoded.resultSrc = 2'b01;
            end
            32'd8: begin
                decoded.memWrite  = 1'b1;
                decoded.resultSrc = 2'b01;
            end
            32'd9: begin
                decoded.jump      = 1'b1;
                decoded.resultSrc = 2'b01;
            end
            32'd10: begin
                decoded.jump      = 1'b1;
                decoded.branch    = 1'b1;
                decoded.resultSrc = 2'b01;
            end
            32'd11: begin
                decoded.branch    = 1'b1;
                decoded.resultSrc = 2'b01;
            end
            default: ;
        endcase
    end

    // Flush beats stall beats idle; an END only counts when it would otherwise load.
    assign running   = (state == RUN);
    assign loadWord  = running && !cu.flush && !cu.stall && cu.instr_valid && !isEnd;
    assign acceptEnd = running && !cu.flush && !cu.stall && cu.instr_valid && isEnd;
    assign runBubble = running && (cu.flush || (!cu.stall && (!cu.instr_valid || isEnd)));
    assign cu.fetch_en = running && !cu.stall;

    always_comb begin
        nextState = state;
        nextCnt   = drainCnt;
        case (state)
            RUN: begin
                if (acceptEnd) begin
                    nextState = DRAIN;
                    nextCnt   = 4'(DRAIN_CYCLES - 1);
                end
            end
            DRAIN: begin
                if (drainCnt == 4'd0) nextState = HALTED;
                else                  nextCnt   = drainCnt - 4'd1;
            end
            HALTED: begin
                if (cu.resume) nextState = RUN;
            end
            default: nextState = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drainCnt  <= 4'd0;
            exReg     <= BUBBLE;
            stopReg   <= 1'b0;
            haltedReg <= 1'b0;
            vgaReg    <= 1'b0;
        end else begin
            state     <= nextState;
            drainCnt  <= nextCnt;
            stopReg   <= acceptEnd;
            haltedReg <= (nextState == HALTED);
            vgaReg    <= (nextState == HALTED);
            if (loadWord)
                exReg <= decoded;
            else if (runBubble || !running)
                exReg <= BUBBLE;
        end
    end

    assign cu.ex_valid    = exReg.exValid;
    assign cu.regWrite    = exReg.regWrite;
    assign cu.memWrite    = exReg.memWrite;
    assign cu.jump        = exReg.jump;
    assign cu.branch      = exReg.branch;
    assign cu.aluSrc      = exReg.aluSrc;
    assign cu.a1Source    = exReg.a1Source;
    assign cu.mxSource    = exReg.mxSource;
    assign cu.resultSrc   = exReg.resultSrc;
    assign cu.aluControl  = exReg.aluControl;
    assign cu.stop        = stopReg;
    assign cu.halted      = haltedReg;
    assign cu.readDataVGA = vgaReg;

`ifdef CU_PERF_COUNTERS_EN
    logic [31:0] instrCnt, bubbleCnt;

    // Bubbles held while HALTED are not counted; both counters saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrCnt  <= 32'd0;
            bubbleCnt <= 32'd0;
        end else begin
            if (loadWord && instrCnt != 32'hFFFF_FFFF)
                instrCnt <= instrCnt + 32'd1;
            if ((runBubble || state == DRAIN) && bubbleCnt != 32'hFFFF_FFFF)
                bubbleCnt <= bubbleCnt + 32'd1;
        end
    end

    assign cu.instr_count  = instrCnt;
    assign cu.bubble_count = bubbleCnt;
`endif
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench: decode vector table, hand-written stall/flush/END/reset sequences, randomized run vs reference model.
module tb_pipelined_control_unit;
    localparam int OP_W  = 4;
    localparam int ALU_W = 4;
    localparam int DRAIN = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_control_unit_if #(.OP_W(OP_W), .ALU_W(ALU_W)) cu ();

    pipelined_control_unit #(.OP_W(OP_W), .ALU_W(ALU_W), .DRAIN_CYCLES(DRAIN)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cu   (cu)
    );

    typedef struct packed {
        logic       ev;
        logic       rw;
        logic [1:0] rs;
        logic       mw;
        logic       j;
        logic       b;
        logic       as;
        logic       a1;
        logic       mx;
        logic [3:0] alu;
    } exp_t;

    typedef struct {
        bit   v;
        int   op;
        bit   imm;
        bit   fl;
        exp_t exp;
    } vec_t;

    int compared   = 0;
    int mismatched = 0;

    // Per-opcode flag tables, transcribed from the decode table (index = opcode 0..12).
    bit rwT [13] = '{1,1,1,1,1,0,1,1,0,0,0,0,0};
    bit rsT [13] = '{0,0,0,0,0,0,0,1,1,1,1,1,0};
    bit mwT [13] = '{0,0,0,0,0,0,0,0,1,0,0,0,0};
    bit jT  [13] = '{0,0,0,0,0,0,0,0,0,1,1,0,0};
    bit bT  [13] = '{0,0,0,0,0,0,0,0,0,0,1,1,0};

    function automatic exp_t mk(bit ev, bit rw, logic [1:0] rs, bit mw, bit j, bit b,
                                bit as, bit a1, bit mx, int alu);
        exp_t e;
        e.ev = ev; e.rw = rw; e.rs = rs; e.mw = mw; e.j = j; e.b = b;
        e.as = as; e.a1 = a1; e.mx = mx; e.alu = 4'(alu);
        return e;
    endfunction

    function automatic exp_t refDecode(int op, bit im);
        exp_t e = '0;
        if (op >= 13) return e;
        e.ev  = 1'b1;
        e.rw  = rwT[op];
        e.rs  = {1'b0, rsT[op]};
        e.mw  = mwT[op];
        e.j   = jT[op];
        e.b   = bT[op];
        e.as  = (op == 5 || op == 6) ? im : 1'b0;
        e.a1  = (op == 5 || op == 6);
        e.mx  = (op == 6) ? im : 1'b0;
        e.alu = (op <= 11) ? 4'(op) : 4'd0;
        return e;
    endfunction

    function automatic exp_t obs();
        return {cu.ex_valid, cu.regWrite, cu.resultSrc, cu.memWrite, cu.jump, cu.branch,
                cu.aluSrc, cu.a1Source, cu.mxSource, cu.aluControl};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(bit v, int op, bit im, bit st, bit fl, bit rs);
        cu.instr_valid = v;
        cu.operation   = OP_W'(op);
        cu.imm         = im;
        cu.stall       = st;
        cu.flush       = fl;
        cu.resume      = rs;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        drive(0, 0, 0, 1, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
    endtask

    vec_t vecs [16];
    exp_t ldrW, strW, addW, mWord;
    bit   rv, rim, rst, rfl, rrs, mHalted, mStop;
    int   rop, sinceEnd;
    int unsigned mInstr, mBubble;

    initial begin
        vecs[0]  = '{1, 0,  0, 0, mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{1, 1,  0, 0, mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 1)};
        vecs[2]  = '{1, 2,  1, 0, mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2)};
        vecs[3]  = '{1, 3,  0, 0, mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 3)};
        vecs[4]  = '{1, 4,  0, 0, mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 4)};
        vecs[5]  = '{1, 5,  0, 0, mk(1, 0, 2'b00, 0, 0, 0, 0, 1, 0, 5)};
        vecs[6]  = '{1, 5,  1, 0, mk(1, 0, 2'b00, 0, 0, 0, 1, 1, 0, 5)};
        vecs[7]  = '{1, 6,  0, 0, mk(1, 1, 2'b00, 0, 0, 0, 0, 1, 0, 6)};
        vecs[8]  = '{1, 6,  1, 0, mk(1, 1, 2'b00, 0, 0, 0, 1, 1, 1, 6)};
        vecs[9]  = '{1, 7,  1, 0, mk(1, 1, 2'b01, 0, 0, 0, 0, 0, 0, 7)};
        vecs[10] = '{1, 8,  0, 0, mk(1, 0, 2'b01, 1, 0, 0, 0, 0, 0, 8)};
        vecs[11] = '{1, 9,  0, 0, mk(1, 0, 2'b01, 0, 1, 0, 0, 0, 0, 9)};
        vecs[12] = '{1, 10, 0, 0, mk(1, 0, 2'b01, 0, 1, 1, 0, 0, 0, 10)};
        vecs[13] = '{1, 11, 0, 0, mk(1, 0, 2'b01, 0, 0, 1, 0, 0, 0, 11)};
        vecs[14] = '{1, 12, 1, 0, mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0)};
        vecs[15] = '{0, 3,  0, 0, '0};
        ldrW = mk(1, 1, 2'b01, 0, 0, 0, 0, 0, 0, 7);
        strW = mk(1, 0, 2'b01, 1, 0, 0, 0, 0, 0, 8);
        addW = mk(1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        doReset();
        check("reset_word", obs(), 0);
        check("reset_stop", cu.stop, 0);
        check("reset_halted", cu.halted, 0);
        check("reset_vga", cu.readDataVGA, 0);
        drive(0, 0, 0, 0, 0, 0);
        #1 check("reset_fetch_en", cu.fetch_en, 1);

        // Decode table
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].imm, 0, vecs[i].fl, 0);
            step();
            check($sformatf("vec%0d_word", i), obs(), vecs[i].exp);
            check($sformatf("vec%0d_stop", i), cu.stop, 0);
        end

        // Stall holds LDR while STR waits
        drive(1, 7, 0, 0, 0, 0); step();
        check("ldr_word", obs(), ldrW);
        drive(1, 8, 0, 1, 0, 0);
        #1 check("stall_fetch_en", cu.fetch_en, 0);
        step(); check("stall_hold1", obs(), ldrW);
        step(); check("stall_hold2", obs(), ldrW);
        drive(1, 8, 0, 0, 0, 0); step();
        check("str_after_stall", obs(), strW);

        // Flush beats stall
        drive(1, 10, 0, 1, 1, 0); step();
        check("flush_stall_bubble", obs(), 0);

        // END, drain, halt, resume
        drive(1, 0, 0, 0, 0, 0); step();
        drive(1, 13, 0, 0, 0, 0);
        #1 check("end_fetch_en_pre", cu.fetch_en, 1);
        step();
        check("end_stop", cu.stop, 1);
        check("end_word", obs(), 0);
        check("end_halted", cu.halted, 0);
        drive(1, 0, 0, 0, 1, 1);
        for (int k = 1; k <= DRAIN; k++) begin
            #1 check($sformatf("drain%0d_fetch_en", k), cu.fetch_en, 0);
            step();
            check($sformatf("drain%0d_stop", k), cu.stop, 0);
            check($sformatf("drain%0d_word", k), obs(), 0);
            check($sformatf("drain%0d_halted", k), cu.halted, (k == DRAIN) ? 1 : 0);
            check($sformatf("drain%0d_vga", k), cu.readDataVGA, (k == DRAIN) ? 1 : 0);
        end
        drive(1, 0, 0, 0, 0, 0);
        repeat (2) begin
            step();
            check("halted_hold", cu.halted, 1);
            check("halted_word", obs(), 0);
            check("halted_fetch_en", cu.fetch_en, 0);
        end
        drive(1, 0, 0, 0, 0, 1); step();
        check("resume_halted", cu.halted, 0);
        check("resume_vga", cu.readDataVGA, 0);
        drive(1, 0, 0, 0, 0, 0);
        #1 check("resume_fetch_en", cu.fetch_en, 1);
        step(); check("resume_add", obs(), addW);

        // END cancelled by flush
        drive(1, 13, 0, 0, 1, 0); step();
        check("endflush_stop", cu.stop, 0);
        check("endflush_word", obs(), 0);
        drive(1, 0, 0, 0, 0, 0);
        #1 check("endflush_fetch_en", cu.fetch_en, 1);
        step(); check("endflush_add", obs(), addW);

        // Asynchronous reset mid-drain
        drive(1, 13, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 0); step();
        #2 rst_n = 1'b0;
        #1;
        check("rstdrain_word", obs(), 0);
        check("rstdrain_halted", cu.halted, 0);
        #2 rst_n = 1'b1;
        #1 check("rstdrain_fetch_en", cu.fetch_en, 1);
        step(); check("rstdrain_add", obs(), addW);
        drive(0, 0, 0, 0, 0, 0);
        repeat (DRAIN + 2) step();
        check("rstdrain_no_halt", cu.halted, 0);

`ifdef CU_PERF_COUNTERS_EN
        doReset();
        check("cnt_reset_instr", cu.instr_count, 0);
        check("cnt_reset_bubble", cu.bubble_count, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, i, 0, 0, 0, 0); step();
        end
        drive(0, 0, 0, 0, 0, 0); step(); step();
        drive(0, 0, 0, 1, 0, 0);
        check("cnt_instr5", cu.instr_count, 5);
        check("cnt_bubble2", cu.bubble_count, 2);
`endif

        // Randomized run against the reference model
        doReset();
        mWord = '0; mHalted = 0; sinceEnd = -1; mInstr = 0; mBubble = 0;
        for (int c = 0; c < 3000; c++) begin
            rv  = ($urandom % 10) < 8;
            rop = $urandom_range(0, 15);
            rim = $urandom % 2;
            rst = ($urandom % 5) == 0;
            rfl = ($urandom % 10) == 0;
            rrs = ($urandom % 4) == 0;
            drive(rv, rop, rim, rst, rfl, rrs);
            #1 check("rand_fetch_en", cu.fetch_en, (!mHalted && sinceEnd < 0 && !rst) ? 1 : 0);
            step();
            mStop = 0;
            if (mHalted) begin
                if (rrs) mHalted = 0;
            end else if (sinceEnd >= 0) begin
                sinceEnd++;
                mWord = '0;
                mBubble++;
                if (sinceEnd == DRAIN) begin
                    mHalted  = 1;
                    sinceEnd = -1;
                end
            end else if (rfl) begin
                mWord = '0;
                mBubble++;
            end else if (rst) begin
                // hold
            end else if (!rv) begin
                mWord = '0;
                mBubble++;
            end else if (rop >= 13) begin
                mWord    = '0;
                mStop    = 1;
                sinceEnd = 0;
                mBubble++;
            end else begin
                mWord = refDecode(rop, rim);
                mInstr++;
            end
            check("rand_word", obs(), mWord);
            check("rand_stop", cu.stop, mStop);
            check("rand_halted", cu.halted, mHalted);
            check("rand_vga", cu.readDataVGA, mHalted);
`ifdef CU_PERF_COUNTERS_EN
            check("rand_instr_count", cu.instr_count, mInstr);
            check("rand_bubble_count", cu.bubble_count, mBubble);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Registered successor to the combinational decoder.
- Decodes an OP_W-bit opcode plus immediate flag into a control word and holds it in a decode/execute pipeline register.
- Handles stall, flush and bubble insertion, and runs an END/halt state machine that drains the pipeline, then hands memory to the VGA reader.
- Sits between instruction fetch/decode and the execute stage of the core.

Parameters:
- OP_W, 4, opcode width; opcodes ≥ 13 decode as END.
- ALU_W, 4, aluControl width; opcode is zero-extended or truncated to ALU_W.
- DRAIN_CYCLES, 3, bubble cycles emitted after END before HALTED; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  fetch presents a valid opcode this cycle
- operation  in  OP_W  opcode
- imm  in  1  immediate-operand flag
- stall  in  1  hold the pipeline register (hazard unit)
- flush  in  1  replace the next register contents with a bubble (taken branch)
- resume  in  1  single-cycle pulse; leaves HALTED
- fetch_en  out  1  combinational; high when state is RUN and stall is 0
- ex_valid  out  1  registered; the control word is a real instruction
- regWrite, memWrite, jump, branch, aluSrc, a1Source, mxSource  out  1 each  registered control flags
- resultSrc  out  2  registered writeback select
- aluControl  out  ALU_W  registered ALU op
- stop  out  1  registered; one-cycle pulse when END is accepted
- halted  out  1  registered; state is HALTED
- readDataVGA  out  1  registered; equals halted

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All registered outputs go to 0 and state goes to RUN.
  - A reset during DRAIN or HALTED returns the block to RUN immediately.
- Decode table (reg, resSrc, mem, j, b, aSrc, a1, mx):
  - ADD 0, SUB 1, AND 2, ORR 3, LSL 4: 1,00,0,0,0,0,0,0.
  - CMP 5: 0,00,0,0,0,imm,1,0. CMP never writes a register, in either operand form.
  - SET 6: 1,00,0,0,0,imm,1,imm.
  - LDR 7: 1,01,0,0,0,0,0,0.
  - STR 8: 0,01,1,0,0,0,0,0.
  - B 9: 0,01,0,1,0,0,0,0.
  - BEQ 10: 0,01,0,1,1,0,0,0.
  - BGE 11: 0,01,0,0,1,0,0,0.
  - NOP 12: all 0, with ex_valid=1.
  - aluControl = opcode for opcodes 0..11; aluControl = 0 for NOP and END.
- Bubble: ex_valid=0, all control flags 0, aluControl=0.
- Latency: one cycle from operation/instr_valid at an edge to the ex_* outputs.
- Pipeline register update priority at each edge (first match wins):
  1. flush=1: load bubble. This overrides stall and cancels an END in the same cycle, so the state stays RUN.
  2. stall=1: hold all ex_* outputs.
  3. instr_valid=0: load bubble.
  4. Otherwise: load the decoded word.
- State machine:
  - RUN:
    - Accepting END (instr_valid=1, stall=0, flush=0, opcode ≥ 13) loads a bubble, pulses stop for one cycle, loads the drain counter with DRAIN_CYCLES-1 and moves to DRAIN.
  - DRAIN:
    - fetch_en=0; operation, imm, instr_valid, stall and flush are ignored; the register loads a bubble every cycle.
    - The counter decrements each cycle; at 0 the state moves to HALTED.
    - Total from END acceptance to halted=1 is DRAIN_CYCLES+1 edges.
  - HALTED:
    - halted=1, readDataVGA=1, bubbles held, fetch_en=0.
    - resume=1 moves to RUN next edge with halted=0 and readDataVGA=0.
    - resume in RUN or DRAIN is ignored.

Optional Feature:
- Macro CU_PERF_COUNTERS_EN.
- When defined, adds two 32-bit registered outputs:
  - instr_count: increments on each edge that loads a non-bubble word (ex_valid goes or stays 1 through a new load; holds during stall). Saturates at 0xFFFFFFFF.
  - bubble_count: increments on each edge that loads a bubble in RUN or DRAIN. Saturates at 0xFFFFFFFF.
  - Both reset to 0 on rst_n only; they hold across HALTED and resume.
- When not defined, the outputs and logic are absent, and the port list is as listed above.

Test Plan:
- Reset then ADD (op 0, valid) → next edge: ex_valid=1, regWrite=1, aluControl=0, resultSrc=00; release rst_n mid-DRAIN → state RUN, all outputs 0.
- CMP with imm=0, then CMP with imm=1 → regWrite=0 both times, a1Source=1, aluSrc=0 then 1, aluControl=5.
- LDR followed by stall=1 for 2 cycles while op changes to STR → ex_* hold the LDR word (resultSrc=01, regWrite=1) for 2 cycles, then show the STR word (memWrite=1).
- BEQ with flush=1 and stall=1 asserted together → next edge loads a bubble (ex_valid=0, jump=0, branch=0).
- END (op 13) with DRAIN_CYCLES=3 → stop pulses one cycle; fetch_en=0; halted=1 and readDataVGA=1 after 4 edges; resume pulse → halted=0 and fetch_en=1 next cycle.
- END with flush=1 in the same cycle → stays RUN, no stop pulse; with CU_PERF_COUNTERS_EN, 5 valid instructions plus 2 idle cycles → instr_count=5, bubble_count=2.
